// File: rtl/mem_rsp_pkg.sv
// mem_rsp_pkg: shared types and helpers for the mem_rsp_sram data-memory responder.
//
// Contents:
//   state_t        responder FSM state (IDLE, WAIT, RESP)
//   WORD_BYTES     bytes per SRAM word / byte lanes per access
//   addr_in_range  true when a byte address falls inside [base, base + depth*4)
package mem_rsp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Word-granular compare: the 30-bit difference wraps for addresses below
    // base, so one unsigned compare rejects both sides of the window.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [29:0] word_off;
        word_off = addr[31:2] - base[31:2];
        return ({2'b00, word_off} < depth);
    endfunction

endpackage

// File: rtl/mem_rsp_sram_if.sv
// mem_rsp_sram_if: request/response bus between the core's memory port
// (master) and the mem_rsp_sram responder (slave).
//
// Handshake: a transfer on either channel happens on a rising clock edge
// where valid and ready are both high. A master holds its request fields
// stable while req_valid_i is high and not yet accepted; the responder holds
// rsp_valid_o and rdata_o stable until rsp_ready_i completes the transfer.
// Ready may be asserted before valid and has no effect on its own.
//
// Signals:
//   req_valid_i / req_ready_o   request channel handshake
//   addr_i, wdata_i, we_i, sel_i  request fields (byte address, lane-aligned
//                               write data, write enable, byte enables)
//   rsp_valid_o / rsp_ready_i   response channel handshake
//   rdata_o                     full read word
//   rsp_err_o                   out-of-range flag (only with MEM_RSP_SRAM_ERR_EN)
interface mem_rsp_sram_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rdata_o;
`ifdef MEM_RSP_SRAM_ERR_EN
    logic        rsp_err_o;

    modport master (
        output req_valid_i, addr_i, wdata_i, we_i, sel_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rdata_o, rsp_err_o
    );
    modport slave (
        input  req_valid_i, addr_i, wdata_i, we_i, sel_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rdata_o, rsp_err_o
    );
`else
    modport master (
        output req_valid_i, addr_i, wdata_i, we_i, sel_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rdata_o
    );
    modport slave (
        input  req_valid_i, addr_i, wdata_i, we_i, sel_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rdata_o
    );
`endif
endinterface

// File: rtl/sram_1rw_be.sv
// sram_1rw_be: single-port synchronous SRAM, 32-bit words, byte enables,
// registered read data.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (read-data register only; the array
//          itself is not reset)
//   en     access enable for this cycle
//   we     1 = write enabled lanes, 0 = read word into rdata
//   be     byte enables, be[n] covers wdata[8n+7:8n]
//   addr   word index
//   wdata  write data
//   rdata  read data, updated only on read accesses, otherwise held
module sram_1rw_be
    import mem_rsp_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_rsp_sram.sv
// mem_rsp_sram: data-memory responder. Accepts one request at a time, waits
// WAIT_CYCLES wait states, performs a word read or byte-enabled write on an
// internal SRAM, then holds the response until the initiator takes it.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two)
//   BASE_ADDR    byte address of word 0, aligned to DEPTH*4
//   WAIT_CYCLES  wait states between accept and response, 0..15
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          mem_rsp_sram_if.slave request/response channel
//   dbg_state_o  current FSM state for observation
//
// Optional feature: define MEM_RSP_SRAM_ERR_EN to add bus.rsp_err_o, high
// together with rsp_valid_o when the captured address was out of range.
module mem_rsp_sram
    import mem_rsp_pkg::*;
#(
    parameter int unsigned DEPTH       = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_rsp_sram_if.slave      bus,
    output state_t             dbg_state_o
);

    localparam int         AW        = $clog2(DEPTH);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
            $error("mem_rsp_sram: WAIT_CYCLES must be within 0..15");
        end
    endgenerate

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rd_zero_q;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we;
    logic [3:0]  cap_sel;

    logic        accept;
    logic        access;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_we;
    logic [3:0]  acc_sel;
    logic        acc_in_range;
    logic        sram_en;
    logic [AW-1:0] sram_addr;
    logic [31:0] sram_rdata;

    assign accept = bus.req_valid_i & req_ready_q;

    // With no wait states the access happens on the accept edge itself, so
    // the SRAM is driven straight from the bus; otherwise from the captured
    // request during the last WAIT cycle.
    always_comb begin
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        acc_we    = cap_we;
        acc_sel   = cap_sel;
        access    = (state == WAIT) && (wait_cnt == 4'd1);
        if (NO_WAIT) begin
            acc_addr  = bus.addr_i;
            acc_wdata = bus.wdata_i;
            acc_we    = bus.we_i;
            acc_sel   = bus.sel_i;
            access    = accept;
        end
    end

    assign acc_in_range = addr_in_range(acc_addr, BASE_ADDR, DEPTH);
    assign sram_en      = access & acc_in_range;
    // BASE_ADDR is DEPTH*4 aligned, so the truncated difference is the index.
    assign sram_addr    = AW'((acc_addr - BASE_ADDR) >> 2);

    sram_1rw_be #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sram_en),
        .we    (acc_we),
        .be    (acc_sel),
        .addr  (sram_addr),
        .wdata (acc_wdata),
        .rdata (sram_rdata)
    );

`ifdef MEM_RSP_SRAM_ERR_EN
    logic rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (access) begin
            rsp_err_q <= !acc_in_range;
        end else if (rsp_valid_q && bus.rsp_ready_i) begin
            rsp_err_q <= 1'b0;
        end
    end

    assign bus.rsp_err_o = rsp_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rd_zero_q   <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_we      <= 1'b0;
            cap_sel     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_addr    <= bus.addr_i;
                        cap_wdata   <= bus.wdata_i;
                        cap_we      <= bus.we_i;
                        cap_sel     <= bus.sel_i;
                        wait_cnt    <= WAIT_LOAD;
                        req_ready_q <= 1'b0;
                        if (NO_WAIT) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            // Writes leave the last read value visible.
                            if (!acc_we) rd_zero_q <= !acc_in_range;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (access) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        if (!acc_we) rd_zero_q <= !acc_in_range;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Out-of-range reads never touch the SRAM, so its read register still
    // holds an older word; the zero flag masks it.
    assign bus.rdata_o     = rd_zero_q ? 32'h0 : sram_rdata;
    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign dbg_state_o     = state;

endmodule

// File: tb/tb_mem_rsp_sram.sv
// tb_mem_rsp_sram: bench for mem_rsp_sram. Four instances: WAIT_CYCLES=1
// (main, checked every cycle against a transaction-level model), 0 and 15
// (back-to-back timing) and 3 (reset during wait states).
module tb_mem_rsp_sram;
    import mem_rsp_pkg::*;

    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          W1    = 1;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst3_n = 1'b0;
    always #5 clk = ~clk;

    mem_rsp_sram_if bus1 ();
    mem_rsp_sram_if b0 ();
    mem_rsp_sram_if b15 ();
    mem_rsp_sram_if b3 ();
    state_t dbg1, dbg0, dbg15, dbg3;

    mem_rsp_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state_o(dbg1));
    mem_rsp_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .dbg_state_o(dbg0));
    mem_rsp_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .bus(b15), .dbg_state_o(dbg15));
    mem_rsp_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .bus(b3), .dbg_state_o(dbg3));

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // ---------------- transaction-level model of dut1 ----------------
    // A request seen while idle is due WAIT_CYCLES edges later; the memory
    // effect and read result land on that edge and the response stays up
    // until the handshake edge.
    logic [31:0] mmem [int unsigned];
    int          cyc = 0;
    int          due = 0;
    bit          busy, m_valid, m_oor;
    logic [31:0] m_rdata;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    logic [3:0]  p_sel;

    task automatic model_access();
        int unsigned off;
        bit          inr;
        logic [31:0] word;
        off  = (p_addr - BASE) >> 2;
        inr  = (off < DEPTH);
        word = (inr && mmem.exists(off)) ? mmem[off] : 32'h0;
        if (p_we) begin
            if (inr) begin
                for (int b = 0; b < 4; b++) if (p_sel[b]) word[8*b +: 8] = p_wdata[8*b +: 8];
                mmem[off] = word;
            end
        end else begin
            m_rdata = word;
        end
        m_oor   = !inr;
        m_valid = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0; m_valid = 0; m_oor = 0; m_rdata = 32'h0;
        end else begin
            cyc++;
            if (m_valid) begin
                if (bus1.rsp_ready_i) begin busy = 0; m_valid = 0; m_oor = 0; end
            end else if (!busy && bus1.req_valid_i) begin
                busy = 1; due = cyc + W1;
                p_addr = bus1.addr_i; p_wdata = bus1.wdata_i;
                p_we = bus1.we_i; p_sel = bus1.sel_i;
            end
            if (busy && !m_valid && cyc == due) model_access();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("req_ready", bus1.req_ready_o, !busy);
            check("rsp_valid", bus1.rsp_valid_o, m_valid);
            check("rdata", bus1.rdata_o, m_rdata);
`ifdef MEM_RSP_SRAM_ERR_EN
            check("rsp_err", bus1.rsp_err_o, m_valid && m_oor);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_bus(virtual mem_rsp_sram_if vif);
        vif.req_valid_i = 0; vif.addr_i = 0; vif.wdata_i = 0;
        vif.we_i = 0; vif.sel_i = 0; vif.rsp_ready_i = 0;
    endtask

    // One full transaction; lat counts cycles from the accept cycle to the
    // first cycle with rsp_valid_o high.
    task automatic vtxn(virtual mem_rsp_sram_if vif, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic we, input logic [3:0] sel,
                        input int stall, output logic [31:0] rd, output int lat);
        int n;
        rd = 32'h0; lat = -1;
        @(negedge clk);
        vif.req_valid_i = 1; vif.addr_i = addr; vif.wdata_i = wdata;
        vif.we_i = we; vif.sel_i = sel; vif.rsp_ready_i = 0;
        n = 0;
        while (!vif.req_ready_o && n < 64) begin @(negedge clk); n++; end
        if (!vif.req_ready_o) begin
            check("accept_timeout", 0, 1); vif.req_valid_i = 0; return;
        end
        @(negedge clk);
        // Scramble the request fields after accept; they must be ignored.
        vif.req_valid_i = 0; vif.addr_i = $urandom; vif.wdata_i = $urandom;
        vif.we_i = 1'($urandom_range(0, 1)); vif.sel_i = 4'($urandom_range(0, 15));
        lat = 1;
        while (!vif.rsp_valid_o && lat < 64) begin @(negedge clk); lat++; end
        if (!vif.rsp_valid_o) begin check("rsp_timeout", 0, 1); return; end
        rd = vif.rdata_o;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_rdata", vif.rdata_o, rd);
            check("stall_valid", vif.rsp_valid_o, 1);
            check("stall_ready", vif.req_ready_o, 0);
        end
        vif.rsp_ready_i = 1;
        @(negedge clk);
        vif.rsp_ready_i = 0;
    endtask

    task automatic b2b(virtual mem_rsp_sram_if vif, input int w, input string nm);
        int acc[$];
        int rise[$];
        @(negedge clk);
        vif.req_valid_i = 1; vif.addr_i = BASE + 32'h8; vif.we_i = 0;
        vif.sel_i = 4'hF; vif.rsp_ready_i = 1;
        for (int i = 0; i < 3 * (w + 2) + 4; i++) begin
            if (vif.req_ready_o) acc.push_back(i);
            if (vif.rsp_valid_o) rise.push_back(i);
            @(negedge clk);
        end
        vif.req_valid_i = 0;
        repeat (w + 4) @(negedge clk);
        vif.rsp_ready_i = 0;
        check({nm, "_count"}, (acc.size() >= 2 && rise.size() >= 2), 1);
        if (acc.size() >= 2 && rise.size() >= 2) begin
            check({nm, "_latency"}, rise[0] - acc[0], w + 1);
            check({nm, "_accept_period"}, acc[1] - acc[0], w + 2);
            check({nm, "_rsp_period"}, rise[1] - rise[0], w + 2);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    int          lat, n;
    bit          seen;

    initial begin
        idle_bus(bus1); idle_bus(b0); idle_bus(b15); idle_bus(b3);
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus1.req_ready_o, 1);
        check("rst_rsp_valid", bus1.rsp_valid_o, 0);
        check("rst_rdata", bus1.rdata_o, 0);
        check("rst_state", 32'(dbg1), 32'(IDLE));
        rst_n = 1; rst3_n = 1;

        // write then read
        vtxn(bus1, 32'h1000_0010, 32'hDEAD_BEEF, 1, 4'hF, 0, rd, lat);
        check("wr_latency", lat, 2);
        vtxn(bus1, 32'h1000_0010, 32'h0, 0, 4'hF, 0, rd, lat);
        check("rd_latency", lat, 2);
        check("rd_deadbeef", rd, 32'hDEAD_BEEF);

        // byte-enable merge
        vtxn(bus1, 32'h1000_0020, 32'h1122_3344, 1, 4'hF, 0, rd, lat);
        vtxn(bus1, 32'h1000_0020, 32'hAABB_CCDD, 1, 4'b0101, 0, rd, lat);
        vtxn(bus1, 32'h1000_0020, 32'h0, 0, 4'hF, 0, rd, lat);
        check("be_merge", rd, 32'h11BB_33DD);

        // backpressure with a second request held during the stall
        @(negedge clk);
        bus1.req_valid_i = 1; bus1.addr_i = 32'h1000_0010; bus1.we_i = 0;
        bus1.sel_i = 4'hF; bus1.rsp_ready_i = 0;
        check("bp_idle_ready", bus1.req_ready_o, 1);
        @(negedge clk);
        bus1.addr_i = 32'h1000_0020;
        n = 0;
        while (!bus1.rsp_valid_o && n < 16) begin @(negedge clk); n++; end
        check("bp_latency", n + 1, 2);
        rd = bus1.rdata_o;
        check("bp_rdata", rd, 32'hDEAD_BEEF);
        repeat (5) begin
            @(negedge clk);
            check("bp_rdata_stable", bus1.rdata_o, rd);
            check("bp_valid_held", bus1.rsp_valid_o, 1);
            check("bp_ready_low", bus1.req_ready_o, 0);
        end
        bus1.rsp_ready_i = 1;
        @(negedge clk);
        bus1.rsp_ready_i = 0;
        check("bp_ready_after_hs", bus1.req_ready_o, 1);
        check("bp_valid_dropped", bus1.rsp_valid_o, 0);
        @(negedge clk);
        bus1.req_valid_i = 0;
        check("bp_held_req_taken", bus1.req_ready_o, 0);
        n = 0;
        while (!bus1.rsp_valid_o && n < 16) begin @(negedge clk); n++; end
        check("bp_held_rdata", bus1.rdata_o, 32'h11BB_33DD);
        bus1.rsp_ready_i = 1;
        @(negedge clk);
        bus1.rsp_ready_i = 0;

        // out-of-range accesses
        vtxn(bus1, BASE, 32'hA5A5_0000, 1, 4'hF, 0, rd, lat);
        vtxn(bus1, BASE + DEPTH * 4 - 4, 32'h5A5A_FFFF, 1, 4'hF, 0, rd, lat);
        vtxn(bus1, 32'h2000_0000, 32'h0, 0, 4'hF, 0, rd, lat);
        check("oor_read_high", rd, 32'h0);
        vtxn(bus1, BASE + DEPTH * 4, 32'h5, 1, 4'hF, 0, rd, lat);
        check("oor_write_rsp_latency", lat, 2);
        vtxn(bus1, BASE, 32'h0, 0, 4'hF, 0, rd, lat);
        check("word0_unchanged", rd, 32'hA5A5_0000);
        vtxn(bus1, BASE + DEPTH * 4 - 4, 32'h0, 0, 4'hF, 0, rd, lat);
        check("word_last_unchanged", rd, 32'h5A5A_FFFF);
        vtxn(bus1, BASE - 4, 32'h0, 0, 4'hF, 0, rd, lat);
        check("oor_read_below", rd, 32'h0);

        // sel = 0 write leaves memory alone
        vtxn(bus1, 32'h1000_0010, 32'hFFFF_FFFF, 1, 4'b0000, 0, rd, lat);
        vtxn(bus1, 32'h1000_0010, 32'h0, 0, 4'hF, 2, rd, lat);
        check("sel0_no_change", rd, 32'hDEAD_BEEF);

        // back-to-back timing for the extreme wait settings
        b2b(b0, 0, "w0");
        b2b(b15, 15, "w15");

        // reset during wait states drops the write
        vtxn(b3, 32'h1000_0040, 32'hCAFE_F00D, 1, 4'hF, 0, rd, lat);
        check("w3_latency", lat, 4);
        @(negedge clk);
        b3.req_valid_i = 1; b3.addr_i = 32'h1000_0040; b3.wdata_i = 32'h1234_5678;
        b3.we_i = 1; b3.sel_i = 4'hF;
        check("w3_idle_ready", b3.req_ready_o, 1);
        @(negedge clk);
        b3.req_valid_i = 0;
        rst3_n = 0;
        seen = 0;
        repeat (3) begin @(negedge clk); seen |= b3.rsp_valid_o; end
        rst3_n = 1;
        repeat (6) begin @(negedge clk); seen |= b3.rsp_valid_o; end
        check("w3_no_rsp_after_reset", seen, 0);
        check("w3_ready_after_reset", b3.req_ready_o, 1);
        vtxn(b3, 32'h1000_0040, 32'h0, 0, 4'hF, 0, rd, lat);
        check("w3_old_contents", rd, 32'hCAFE_F00D);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
